// File: rtl/traffic_ctrl_n.sv
// traffic_ctrl_n: N-way traffic-light sequencer with a one-second tick prescaler,
// hold/freeze input and status outputs.
// Optional build macro DEMAND_SKIP_EN adds the req input. The controller then serves
// only directions with demand and skips the others. Without the macro it runs a fixed
// round-robin.
//
// state      | meaning
// -----------+--------------------------------------------------------------
// ST_STARTUP | all approaches yellow after reset
// ST_GREEN   | direction dir_q green, all others red
// ST_YELLOW  | dir_q (outgoing) and nxt_q (incoming) yellow, others red
// 2'b11      | unreachable; recovers to ST_STARTUP with all lights red
module traffic_ctrl_n #(
  parameter int NUM_DIR     = 4,
  parameter int TICK_DIV    = 50000000,
  parameter int GREEN_SEC   = 5,
  parameter int YELLOW_SEC  = 1,
  parameter int STARTUP_SEC = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 hold,
`ifdef DEMAND_SKIP_EN
  input  logic [NUM_DIR-1:0]   req,
`endif
  output logic [2*NUM_DIR-1:0] lights,
  output logic [2:0]           active_dir,
  output logic [1:0]           phase,
  output logic                 sec_tick
);

  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_TOP = PRE_W'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    ST_STARTUP = 2'b00,
    ST_GREEN   = 2'b01,
    ST_YELLOW  = 2'b10
  } state_t;

  state_t                 state_q, state_d;
  logic [PRE_W-1:0]       pre_q, pre_d;
  logic [31:0]            sec_q, sec_d;
  logic [31:0]            dur;
  logic [2:0]             dir_q, dir_d;
  logic [2:0]             nxt_q, nxt_d;
  logic [2*NUM_DIR-1:0]   lights_d;
  logic                   last_sec;
  logic                   has_other;
  logic [2:0]             serve;

  function automatic logic [2:0] succ(input logic [2:0] d);
    return (int'(d) >= NUM_DIR - 1) ? 3'd0 : d + 3'd1;
  endfunction

  // Tick is consumed only while running; hold masks it.
  assign sec_tick   = (pre_q == PRE_TOP) && !hold;
  assign active_dir = dir_q;
  assign phase      = 2'(state_q);

  // Choose the direction to serve after the current green.
  always_comb begin
    has_other = 1'b1;
    serve     = succ(dir_q);
`ifdef DEMAND_SKIP_EN
    has_other = 1'b0;
    serve     = dir_q;
    for (int k = 1; k < NUM_DIR; k++) begin
      if (!has_other && req[(int'(dir_q) + k) % NUM_DIR]) begin
        has_other = 1'b1;
        serve     = 3'((int'(dir_q) + k) % NUM_DIR);
      end
    end
`endif
  end

  // Next-state, counter and light computation.
  always_comb begin
    state_d  = state_q;
    pre_d    = pre_q;
    sec_d    = sec_q;
    dir_d    = dir_q;
    nxt_d    = nxt_q;
    lights_d = lights;
    dur      = 32'(STARTUP_SEC);
    case (state_q)
      ST_GREEN:  dur = 32'(GREEN_SEC);
      ST_YELLOW: dur = 32'(YELLOW_SEC);
      default:   dur = 32'(STARTUP_SEC);
    endcase
    last_sec = sec_tick && (sec_q == dur - 32'd1);

    if (state_q != ST_STARTUP && state_q != ST_GREEN && state_q != ST_YELLOW) begin
      // Corrupted encoding: restart cleanly, show red for one cycle.
      state_d  = ST_STARTUP;
      pre_d    = '0;
      sec_d    = '0;
      dir_d    = 3'd0;
      nxt_d    = 3'd0;
      lights_d = '0;
    end else if (!hold) begin
      pre_d = (pre_q == PRE_TOP) ? '0 : pre_q + PRE_W'(1);
      if (sec_tick) sec_d = last_sec ? 32'd0 : sec_q + 32'd1;
      if (last_sec) begin
        case (state_q)
          ST_STARTUP: begin
            state_d = ST_GREEN;
            dir_d   = 3'd0;
          end
          ST_GREEN: begin
            if (has_other) begin
              state_d = ST_YELLOW;
              nxt_d   = serve;
            end
          end
          default: begin
            state_d = ST_GREEN;
            dir_d   = nxt_q;
          end
        endcase
      end
      for (int i = 0; i < NUM_DIR; i++) begin
        case (state_d)
          ST_STARTUP: lights_d[2*(NUM_DIR-i)-1 -: 2] = 2'b01;
          ST_GREEN:   lights_d[2*(NUM_DIR-i)-1 -: 2] = (3'(i) == dir_d) ? 2'b10 : 2'b00;
          default:    lights_d[2*(NUM_DIR-i)-1 -: 2] =
                        (3'(i) == dir_d || 3'(i) == nxt_d) ? 2'b01 : 2'b00;
        endcase
      end
    end
  end

  // State and output registers; reset wins over hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_STARTUP;
      pre_q   <= '0;
      sec_q   <= '0;
      dir_q   <= 3'd0;
      nxt_q   <= 3'd0;
      lights  <= {NUM_DIR{2'b01}};
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      sec_q   <= sec_d;
      dir_q   <= dir_d;
      nxt_q   <= nxt_d;
      lights  <= lights_d;
    end
  end

endmodule

// File: tb/tb_traffic_ctrl_n.sv
// Self-checking bench for traffic_ctrl_n: a 4-way and a 3-way instance run side by side
// against a timeline model (phase position derived from unheld cycles since reset).
module tb_traffic_ctrl_n;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset = 1'b1;
  logic hold  = 1'b0;

  logic [7:0] lights4;
  logic [2:0] ad4;
  logic [1:0] ph4;
  logic       st4;
  logic [5:0] lights3;
  logic [2:0] ad3;
  logic [1:0] ph3;
  logic       st3;
`ifdef DEMAND_SKIP_EN
  logic [3:0] req = 4'hF;
`endif

  traffic_ctrl_n #(.NUM_DIR(4), .TICK_DIV(4), .GREEN_SEC(2), .YELLOW_SEC(1), .STARTUP_SEC(1)) dut4 (
    .clk(clk), .reset(reset), .hold(hold),
`ifdef DEMAND_SKIP_EN
    .req(req),
`endif
    .lights(lights4), .active_dir(ad4), .phase(ph4), .sec_tick(st4));

  traffic_ctrl_n #(.NUM_DIR(3), .TICK_DIV(4), .GREEN_SEC(2), .YELLOW_SEC(1), .STARTUP_SEC(1)) dut3 (
    .clk(clk), .reset(reset), .hold(hold),
`ifdef DEMAND_SKIP_EN
    .req(req[2:0]),
`endif
    .lights(lights3), .active_dir(ad3), .phase(ph3), .sec_tick(st3));

  typedef struct {
    logic [7:0] l4;
    logic [2:0] a4;
    logic [1:0] p4;
    logic       s4;
    logic [5:0] l3;
    logic [2:0] a3;
    logic [1:0] p3;
    logic       s3;
  } exp_t;

  exp_t sb[$];
  logic [7:0] sbd[$];
  int errors = 0;
  int checks = 0;
  int t_eff  = 0;
  bit started = 0;

  // Timeline: 4 startup cycles, then per direction 8 green + 4 yellow cycles.
  function automatic void model(input int n, input int t, output logic [15:0] l,
                                output logic [2:0] ad, output logic [1:0] ph);
    int u, d, r, nx;
    l = '0; ad = 3'd0; ph = 2'd0;
    if (t < 4) begin
      for (int k = 0; k < n; k++) l = l | (16'd1 << (2*(n-1-k)));
    end else begin
      u = (t - 4) % (n * 12);
      d = u / 12;
      r = u % 12;
      nx = (d + 1) % n;
      ad = 3'(d);
      if (r < 8) begin
        ph = 2'd1;
        l = 16'd2 << (2*(n-1-d));
      end else begin
        ph = 2'd2;
        l = (16'd1 << (2*(n-1-d))) | (16'd1 << (2*(n-1-nx)));
      end
    end
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h (t_eff=%0d)", tag, obs, expv, t_eff);
    end
  endtask

  task automatic step(input logic h, input logic r);
    exp_t e, g;
    logic [15:0] l;
    @(negedge clk);
    hold = h;
    reset = r;
    if (started) begin
      model(4, t_eff, l, e.a4, e.p4);
      e.l4 = l[7:0];
      model(3, t_eff, l, e.a3, e.p3);
      e.l3 = l[5:0];
      e.s4 = ((t_eff % 4) == 3) && !h;
      e.s3 = e.s4;
      sb.push_back(e);
    end
    #1;
    if (started && sb.size() > 0) begin
      g = sb.pop_front();
      chk("lights4", 16'(lights4), 16'(g.l4));
      chk("active4", 16'(ad4), 16'(g.a4));
      chk("phase4",  16'(ph4), 16'(g.p4));
      chk("tick4",   16'(st4), 16'(g.s4));
      chk("lights3", 16'(lights3), 16'(g.l3));
      chk("active3", 16'(ad3), 16'(g.a3));
      chk("phase3",  16'(ph3), 16'(g.p3));
      chk("tick3",   16'(st3), 16'(g.s3));
    end
    @(posedge clk);
    if (r) begin
      t_eff = 0;
      started = 1;
    end else if (!h) begin
      t_eff++;
    end
  endtask

  task automatic step_d(input logic [7:0] expl);
    logic [7:0] g;
    @(negedge clk);
    hold = 1'b0;
    reset = 1'b0;
    sbd.push_back(expl);
    #1;
    g = sbd.pop_front();
    chk("demand_lights4", 16'(lights4), 16'(g));
    @(posedge clk);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
    for (int i = 0; i < 60; i++) step(1'b0, 1'b0);
    while (t_eff < 55) step(1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0);
    while (t_eff < 73) step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0);
`ifdef DEMAND_SKIP_EN
    req = 4'b0101;
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    for (int c = 0; c < 17; c++)
      step_d(c < 4 ? 8'h55 : c < 12 ? 8'h80 : c < 16 ? 8'h44 : 8'h08);
    req = 4'b0001;
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    for (int c = 0; c < 28; c++) step_d(c < 4 ? 8'h55 : 8'h80);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
